fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, maximum cycles a memory request may stay outstanding before timeout.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port srst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall_d  input  1  decode stage cannot accept the held instruction this cycle.
REQ-006 SHALL have port pcsrc_e  input  1  execute-stage redirect (taken branch/jal).
REQ-007 SHALL have port pc_target_e  input  32  redirect target, valid when pcsrc_e=1.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request, held until imem_rvalid.
REQ-009 SHALL have port imem_addr  output  32  request address, stable while imem_req=1.
REQ-010 SHALL have port imem_rvalid  input  1  one-cycle response strobe, exactly one per request.
REQ-011 SHALL have port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-012 SHALL have port instr_f  output  32  fetched instruction presented to decode.
REQ-013 SHALL have port pc_f  output  32  address of instr_f.
REQ-014 SHALL have port pc_plus4_f  output  32  pc_f+4.
REQ-015 SHALL have port instr_valid_f  output  1  instr_f valid; consumed when instr_valid_f=1 and stall_d=0.
REQ-016 SHALL have port timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-017 SHALL implement states IDLE, REQ, HOLD, DISCARD; internal fetch_pc drives imem_addr.
REQ-018 IDLE: imem_req=0; next state REQ unconditionally.
REQ-019 REQ: imem_req=1; on imem_rvalid with pcsrc_e=0 capture instr_f<=imem_rdata, pc_f<=fetch_pc, instr_valid_f<=1, fetch_pc<=fetch_pc+4, go HOLD.
REQ-020 REQ with pcsrc_e=1 and imem_rvalid=0: fetch_pc<=pc_target_e, go DISCARD; imem_req stays 1, imem_addr keeps the old address until the response.
REQ-021 REQ with pcsrc_e=1 and imem_rvalid=1 same cycle: response dropped, fetch_pc<=pc_target_e, stay REQ (new request next cycle), instr_valid_f stays 0.
REQ-022 DISCARD: imem_req=1 with old address; on imem_rvalid drop data, go REQ; further pcsrc_e in DISCARD overwrites fetch_pc with latest pc_target_e.
REQ-023 HOLD: imem_req=0, instr_f/pc_f/instr_valid_f held; when stall_d=0 instr consumed: instr_valid_f<=0, go REQ.
REQ-024 HOLD with pcsrc_e=1 (priority over stall_d): instr_valid_f<=0, fetch_pc<=pc_target_e, go REQ.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 pc_plus4_f SHALL be combinational from pc_f.
REQ-027 wait_cnt SHALL count cycles in REQ/DISCARD, clear on imem_rvalid, saturate at MAX_WAIT+1.
REQ-028 timeout_err SHALL set the cycle wait_cnt reaches MAX_WAIT+1 and hold until reset; fetching continues unchanged.
REQ-029 imem_rvalid outside REQ/DISCARD SHALL be ignored.

Reset
REQ-030 srst_n=0 SHALL asynchronously force state IDLE, fetch_pc=RESET_PC, pc_f=RESET_PC, instr_f=0, instr_valid_f=0, wait_cnt=0, timeout_err=0, imem_req=0.
REQ-031 Reset mid-request SHALL abandon the outstanding request; the memory is reset by the same srst_n.

Structure
REQ-032 State enum and RESET_PC default SHALL live in the shared pipeline package.
REQ-033 Single module; the +4 adder is shared between fetch_pc and pc_plus4_f, no sub-module.

Verification
REQ-034 Reset release, memory latency 1, rdata 32'h0000_0013 -> imem_addr=0, instr_valid_f=1 at cycle 3, pc_f=0, pc_plus4_f=4.
REQ-035 stall_d=1 for 4 cycles in HOLD -> instr_f/pc_f constant, imem_req=0; stall_d=0 -> next request to address 4.
REQ-036 Latency 3, pcsrc_e=1 target 32'h100 one cycle after request -> old response dropped, next imem_addr=32'h100, no instr_valid_f for the old word.
REQ-037 pcsrc_e and imem_rvalid same cycle, target 32'h40 -> instr_valid_f stays 0, next request address 32'h40.
REQ-038 Memory never responds -> timeout_err=1 after 16 cycles in REQ, stays 1 after response arrives.
REQ-039 Redirect to 32'hFFFF_FFFC -> pc_f=32'hFFFF_FFFC, pc_plus4_f=0, next fetch address 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline definitions for the fetch stage: state encoding, reset
// address default and timeout counter sizing.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          MAX_WAIT_DEFAULT = 15;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    // wait counter must be able to hold MAX_WAIT+1 (its saturation value)
    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 2);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time, holds the
// fetched word for decode, and squashes in-flight words on execute redirects.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | one cycle after reset, no request
// ST_REQ     | request to fetch_pc outstanding, waiting for imem_rvalid
// ST_HOLD    | instr_f valid, waiting for decode to consume it
// ST_DISCARD | redirected while a request was in flight; drop its response
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        stall_d,
    input  logic        pcsrc_e,
    input  logic [31:0] pc_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        instr_valid_f,
    output logic        timeout_err
);

    localparam int             WCW      = wait_cnt_width(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_TRIP = WCW'(MAX_WAIT);

    fetch_state_t   state, state_nxt;
    logic [31:0]    fetch_pc, fetch_pc_nxt;
    logic [31:0]    disc_addr, disc_addr_nxt;
    logic [31:0]    instr_nxt;
    logic [31:0]    pc_f_nxt;
    logic           valid_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           waiting;

    // Single +4 adder. fetch_pc is left equal to pc_f on capture and advanced
    // to pc_f+4 at consume time, so both uses share this one adder; fetch_pc
    // is only visible on imem_addr while imem_req=1, where both agree.
    assign pc_plus4_f = pc_f + INSTR_BYTES;

    assign waiting = (state == ST_REQ) || (state == ST_DISCARD);

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        disc_addr_nxt = disc_addr;
        instr_nxt     = instr_f;
        pc_f_nxt      = pc_f;
        valid_nxt     = instr_valid_f;
        imem_req      = 1'b0;
        imem_addr     = fetch_pc;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end

            ST_REQ: begin
                imem_req = 1'b1;
                if (pcsrc_e) begin
                    fetch_pc_nxt = pc_target_e;
                    if (!imem_rvalid) begin
                        disc_addr_nxt = fetch_pc;
                        state_nxt     = ST_DISCARD;
                    end
                end else if (imem_rvalid) begin
                    instr_nxt = imem_rdata;
                    pc_f_nxt  = fetch_pc;
                    valid_nxt = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end

            ST_DISCARD: begin
                // memory still owes the old address its response
                imem_req  = 1'b1;
                imem_addr = disc_addr;
                if (pcsrc_e) begin
                    fetch_pc_nxt = pc_target_e;
                end
                if (imem_rvalid) begin
                    state_nxt = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (pcsrc_e) begin
                    valid_nxt    = 1'b0;
                    fetch_pc_nxt = pc_target_e;
                    state_nxt    = ST_REQ;
                end else if (!stall_d) begin
                    valid_nxt    = 1'b0;
                    fetch_pc_nxt = pc_plus4_f;
                    state_nxt    = ST_REQ;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state         <= ST_IDLE;
            fetch_pc      <= RESET_PC;
            disc_addr     <= RESET_PC;
            instr_f       <= 32'h0000_0000;
            pc_f          <= RESET_PC;
            instr_valid_f <= 1'b0;
        end else begin
            state         <= state_nxt;
            fetch_pc      <= fetch_pc_nxt;
            disc_addr     <= disc_addr_nxt;
            instr_f       <= instr_nxt;
            pc_f          <= pc_f_nxt;
            instr_valid_f <= valid_nxt;
        end
    end

    // Timeout only flags a slow memory; the FSM keeps waiting regardless.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (waiting) begin
            if (imem_rvalid) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + WCW'(1);
                if (wait_cnt == WAIT_TRIP) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a latency-programmable memory model checks request
// addresses against an expected queue, and a monitor checks each presented
// instruction against an expected-instruction queue.
module tb_fetch_ctrl;

    logic        clk         = 1'b0;
    logic        srst_n      = 1'b0;
    logic        stall_d     = 1'b1;
    logic        pcsrc_e     = 1'b0;
    logic [31:0] pc_target_e = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        instr_valid_f;
    logic        timeout_err;

    fetch_ctrl dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .stall_d      (stall_d),
        .pcsrc_e      (pcsrc_e),
        .pc_target_e  (pc_target_e),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_f      (instr_f),
        .pc_f         (pc_f),
        .pc_plus4_f   (pc_plus4_f),
        .instr_valid_f(instr_valid_f),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          errors = 0;
    int          checks = 0;

    int          lat        = 1;
    bit          respond_en = 1'b1;
    bit          stray_req  = 1'b0;
    bit          m_busy     = 1'b0;
    int          m_cnt      = 0;
    logic [31:0] m_addr     = 32'h0;
    bit          prev_v     = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0], 16'h0b37};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.pc4   = p4;
        exp_q.push_back(e);
    endtask

    // memory model: accepts a request, answers lat cycles later
    always @(negedge clk) begin
        if (!srst_n) begin
            m_busy      = 1'b0;
            imem_rvalid = 1'b0;
            stray_req   = 1'b0;
        end else begin
            if (imem_rvalid) begin
                imem_rvalid = 1'b0;
                m_busy      = 1'b0;
            end else if (m_busy) begin
                check32("req_held", {31'b0, imem_req}, 32'd1);
                check32("req_addr_stable", imem_addr, m_addr);
                if (m_cnt > 0) m_cnt--;
                if (m_cnt == 0 && respond_en) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(m_addr);
                end
            end
            if (!m_busy && imem_req) begin
                m_busy = 1'b1;
                m_cnt  = lat;
                m_addr = imem_addr;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h, no request expected", imem_addr);
                end else begin
                    check32("req_addr", imem_addr, addr_q.pop_front());
                end
            end else if (!m_busy && stray_req) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                stray_req   = 1'b0;
            end
        end
    end

    // monitor: every new instruction presentation is scored
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!srst_n) begin
            prev_v = 1'b0;
        end else begin
            if (instr_valid_f && !prev_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got instr %h pc %h, none expected", instr_f, pc_f);
                end else begin
                    e = exp_q.pop_front();
                    check32("instr_f", instr_f, e.instr);
                    check32("pc_f", pc_f, e.pc);
                    check32("pc_plus4_f", pc_plus4_f, e.pc4);
                end
            end
            prev_v = instr_valid_f;
        end
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        srst_n     = 1'b0;
        pcsrc_e    = 1'b0;
        stall_d    = 1'b1;
        lat        = l;
        respond_en = 1'b1;
        repeat (2) @(negedge clk);
        check32("leftover_exp_instr", exp_q.size(), 32'd0);
        check32("leftover_exp_addr", addr_q.size(), 32'd0);
        exp_q.delete();
        addr_q.delete();
        check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check32("rst_valid", {31'b0, instr_valid_f}, 32'd0);
        check32("rst_instr_f", instr_f, 32'h0);
        check32("rst_pc_f", pc_f, 32'h0);
        check32("rst_pc_plus4_f", pc_plus4_f, 32'h4);
        check32("rst_timeout", {31'b0, timeout_err}, 32'd0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        srst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid_f && n < 40) begin
            @(negedge clk);
            n++;
        end
        check32(name, {31'b0, instr_valid_f}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check32(name, {31'b0, imem_req}, 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        stall_d = 1'b0;
        @(negedge clk);
        stall_d = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        pcsrc_e     = 1'b1;
        pc_target_e = tgt;
        @(negedge clk);
        pcsrc_e     = 1'b0;
    endtask

    initial begin
        // basic fetch, latency 1: valid exactly in cycle 3
        do_reset(1);
        addr_q.push_back(32'h0);
        push_exp(32'h13, 32'h0, 32'h4);
        release_rst();
        repeat (2) @(posedge clk);
        #1 check32("t1_valid_cycle2", {31'b0, instr_valid_f}, 32'd0);
        @(posedge clk);
        #1 check32("t1_valid_cycle3", {31'b0, instr_valid_f}, 32'd1);

        // stall in HOLD keeps everything still
        repeat (4) begin
            @(negedge clk);
            check32("t2_hold_instr", instr_f, 32'h13);
            check32("t2_hold_pc", pc_f, 32'h0);
            check32("t2_hold_req", {31'b0, imem_req}, 32'd0);
            check32("t2_hold_valid", {31'b0, instr_valid_f}, 32'd1);
        end
        addr_q.push_back(32'h4);
        push_exp(mem_word(32'h4), 32'h4, 32'h8);
        consume();
        wait_valid("t2_fetch4");

        // redirect one cycle into a latency-3 request
        do_reset(3);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h100);
        push_exp(mem_word(32'h100), 32'h100, 32'h104);
        release_rst();
        wait_req("t3_req");
        @(negedge clk);
        redirect(32'h100);
        wait_valid("t3_fetch100");
        check32("t3_no_timeout", {31'b0, timeout_err}, 32'd0);

        // two redirects while discarding: latest target wins; stray rvalid in HOLD
        do_reset(3);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h200);
        push_exp(mem_word(32'h200), 32'h200, 32'h204);
        release_rst();
        wait_req("t7_req");
        @(negedge clk);
        pcsrc_e     = 1'b1;
        pc_target_e = 32'h100;
        @(negedge clk);
        redirect(32'h200);
        wait_valid("t7_fetch200");
        stray_req = 1'b1;
        repeat (3) @(negedge clk);
        check32("t7_stray_instr", instr_f, mem_word(32'h200));
        check32("t7_stray_pc", pc_f, 32'h200);
        check32("t7_stray_valid", {31'b0, instr_valid_f}, 32'd1);
        check32("t7_stray_req", {31'b0, imem_req}, 32'd0);

        // redirect in the same cycle as the response
        do_reset(1);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h40);
        push_exp(mem_word(32'h40), 32'h40, 32'h44);
        release_rst();
        wait_req("t4_req");
        @(negedge clk);
        redirect(32'h40);
        check32("t4_no_valid", {31'b0, instr_valid_f}, 32'd0);
        check32("t4_req_again", {31'b0, imem_req}, 32'd1);
        wait_valid("t4_fetch40");

        // memory silent: timeout after 16 cycles in REQ, sticky
        do_reset(1);
        respond_en = 1'b0;
        addr_q.push_back(32'h0);
        release_rst();
        repeat (16) @(posedge clk);
        #1 check32("t5_timeout_pre", {31'b0, timeout_err}, 32'd0);
        @(posedge clk);
        #1 check32("t5_timeout_set", {31'b0, timeout_err}, 32'd1);
        @(negedge clk);
        push_exp(32'h13, 32'h0, 32'h4);
        respond_en = 1'b1;
        wait_valid("t5_late_fetch");
        repeat (3) @(negedge clk);
        check32("t5_timeout_sticky", {31'b0, timeout_err}, 32'd1);

        // redirect from HOLD (with stall) to the top of the address space
        do_reset(1);
        addr_q.push_back(32'h0);
        push_exp(32'h13, 32'h0, 32'h4);
        release_rst();
        wait_valid("t6_first");
        addr_q.push_back(32'hFFFF_FFFC);
        push_exp(mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
        redirect(32'hFFFF_FFFC);
        check32("t6_redirect_drops", {31'b0, instr_valid_f}, 32'd0);
        wait_valid("t6_fetch_top");
        check32("t6_pc_plus4_wrap", pc_plus4_f, 32'h0);
        addr_q.push_back(32'h0);
        push_exp(32'h13, 32'h0, 32'h4);
        consume();
        wait_valid("t6_wrap_fetch");

        do_reset(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
